// File: rtl/mem_hash_pkg.sv
// rtl/mem_hash_pkg.sv - shared constants, row type and loader FSM states
package mem_hash_pkg;

    localparam int         ROW_WORDS = 32;
    localparam logic [4:0] ADDR_LAST = 5'd31;

    typedef logic [ROW_WORDS*32-1:0] row_t;

    typedef enum logic {
        RUN = 1'b0,
        PAD = 1'b1
    } ld_state_e;

endpackage

// File: rtl/mem_hash_skid.sv
// rtl/mem_hash_skid.sv - 2-entry valid/ready skid buffer with occupancy output
module mem_hash_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       cnt_q;
    logic             push;
    logic             pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    // Head is read straight from storage, so it cannot change while stalled.
    assign out_data  = mem[rd_ptr];
    assign count     = cnt_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/mem_hash_loader.sv
// rtl/mem_hash_loader.sv - row sequencer feeding the mem_hash load port with credit and gap gating
module mem_hash_loader
    import mem_hash_pkg::*;
#(
    parameter int N        = 32,
    parameter int M        = 16,
    parameter int ID_WIDTH = 32,
    parameter int INIT_GAP = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [N*32-1:0]       s_data,
    input  logic [ID_WIDTH-1:0]   s_index,
    input  logic                  s_last,
    output logic                  out_valid,
    input  logic                  down_ready,
    output logic [4:0]            out_addr,
    output logic [ID_WIDTH-1:0]   out_index,
    output logic [N*32-1:0]       out_data,
    input  logic                  done,
    output logic [$clog2(M):0]    inflight,
    output logic                  err
);

    localparam int DW = N * 32;
    localparam int EW = DW + 5 + ID_WIDTH;
    localparam int IW = $clog2(M) + 1;
    localparam int GW = $clog2(INIT_GAP) + 1;

    ld_state_e           state_q, state_d;
    logic [4:0]          s_cnt_q, s_cnt_d;
    logic [ID_WIDTH-1:0] job_idx_q, job_idx_d;
    logic                err_q, err_d;
    logic                s_ready_q;
    logic [GW-1:0]       gap_q;
    logic [IW-1:0]       inflight_q;

    logic                in_fire;
    logic                push_req;
    logic                push_fire;
    logic [DW-1:0]       push_data;
    logic [4:0]          push_addr;
    logic [ID_WIDTH-1:0] push_idx;
    logic                skid_in_ready;
    logic                skid_valid;
    logic [EW-1:0]       head;
    logic [1:0]          skid_cnt;
    logic [1:0]          cnt_next;
    logic                head_ok;
    logic                pop;
    logic                last_pop;
    logic                credit_ret;

    assign in_fire = s_valid && s_ready_q && (state_q == RUN);

    always_comb begin
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        job_idx_d = job_idx_q;
        err_d     = err_q;
        push_req  = 1'b0;
        push_data = '0;
        push_addr = s_cnt_q;
        push_idx  = job_idx_q;
        case (state_q)
            RUN: begin
                if (in_fire) begin
                    push_req  = 1'b1;
                    push_data = s_data;
                    if (s_cnt_q == 5'd0) begin
                        push_idx  = s_index;
                        job_idx_d = s_index;
                    end
                    if (s_cnt_q == ADDR_LAST) begin
                        s_cnt_d = 5'd0;
                        if (!s_last) err_d = 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                        // Early end of job: keep the beat, then fill the rest with zero rows.
                        if (s_last) begin
                            err_d   = 1'b1;
                            state_d = PAD;
                        end
                    end
                end
            end
            PAD: begin
                push_req = 1'b1;
                if (skid_in_ready) begin
                    if (s_cnt_q == ADDR_LAST) begin
                        s_cnt_d = 5'd0;
                        state_d = RUN;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
        if (done && (inflight_q == '0)) err_d = 1'b1;
    end

    assign push_fire = push_req && skid_in_ready;

    mem_hash_skid #(
        .WIDTH (EW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push_req),
        .in_data   ({push_data, push_addr, push_idx}),
        .in_ready  (skid_in_ready),
        .out_valid (skid_valid),
        .out_data  (head),
        .out_ready (head_ok && down_ready),
        .count     (skid_cnt)
    );

    assign out_data  = head[EW-1 -: DW];
    assign out_addr  = head[ID_WIDTH +: 5];
    assign out_index = head[ID_WIDTH-1:0];

    // Only the final row of a job consumes a lane, so only it waits for gap and credit.
    assign head_ok    = (out_addr != ADDR_LAST) || ((gap_q == '0) && (inflight_q < IW'(M)));
    assign out_valid  = skid_valid && head_ok;
    assign pop        = out_valid && down_ready;
    assign last_pop   = pop && (out_addr == ADDR_LAST);
    assign credit_ret = done && (inflight_q != '0);
    assign cnt_next   = skid_cnt + {1'b0, push_fire} - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            s_cnt_q    <= 5'd0;
            job_idx_q  <= '0;
            err_q      <= 1'b0;
            s_ready_q  <= 1'b0;
            gap_q      <= '0;
            inflight_q <= '0;
        end else begin
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            job_idx_q <= job_idx_d;
            err_q     <= err_d;
            s_ready_q <= (cnt_next != 2'd2) && (state_d == RUN);
            if (last_pop) begin
                gap_q <= GW'(INIT_GAP - 1);
            end else if (gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end
            if (last_pop && !credit_ret) begin
                inflight_q <= inflight_q + 1'b1;
            end else if (!last_pop && credit_ret) begin
                inflight_q <= inflight_q - 1'b1;
            end
        end
    end

    assign s_ready  = s_ready_q;
    assign inflight = inflight_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_hash_loader.sv
// tb/tb_mem_hash_loader.sv - directed self-checking bench for mem_hash_loader
module tb_mem_hash_loader;

    localparam int N = 32;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
        logic [31:0] idx;
        int          cyc;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [N*32-1:0] s_data = '0;
    logic [31:0]     s_index = '0;
    logic            s_last = 1'b0;
    logic            out_valid;
    logic            down_ready = 1'b1;
    logic [4:0]      out_addr;
    logic [31:0]     out_index;
    logic [N*32-1:0] out_data;
    logic            done = 1'b0;
    logic [4:0]      inflight;
    logic            err;

    int              n_checks = 0;
    int              n_errors = 0;
    int              cyc = 0;
    beat_t           mon_q[$];
    int              in_cyc_q[$];
    logic            saw_block = 1'b0;
    logic            stall_prev = 1'b0;
    logic [63:0]     prev_word = '0;
    logic [3:0]      bp_pat = 4'b1001;
    int              prev_c;

    always #5 clk = ~clk;

    mem_hash_loader #(
        .N        (N),
        .M        (16),
        .ID_WIDTH (32),
        .INIT_GAP (40)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_index    (s_index),
        .s_last     (s_last),
        .out_valid  (out_valid),
        .down_ready (down_ready),
        .out_addr   (out_addr),
        .out_index  (out_index),
        .out_data   (out_data),
        .done       (done),
        .inflight   (inflight),
        .err        (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("hold_stable", {out_valid, out_addr, out_index, out_data[25:0]}, {1'b1, prev_word[62:0]});
            if (out_valid && down_ready)
                mon_q.push_back('{out_addr, out_data[63:0], out_index, cyc});
            if (s_valid && s_ready) in_cyc_q.push_back(cyc);
            if (s_valid && !s_ready) saw_block = 1'b1;
            stall_prev = out_valid && !down_ready;
            prev_word  = {1'b1, out_addr, out_index, out_data[25:0]};
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic [31:0] idx, input logic last);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = '0;
        s_data[31:0] = d;
        s_index = idx;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) check("s_ready_timeout", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_job(input logic [31:0] idx, input logic [31:0] base, input int last_at);
        @(posedge clk); #1;
        for (int k = 0; k <= last_at; k++)
            send_beat(base + k, (k == 0) ? idx : ~idx, k == last_at);
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int c;
        c = 0;
        while (mon_q.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        check(tag, 64'(mon_q.size()), 64'(n));
    endtask

    function automatic int count31();
        int n;
        n = 0;
        foreach (mon_q[i]) if (mon_q[i].addr == 5'd31) n++;
        return n;
    endfunction

    task automatic check_job(input int start, input logic [31:0] idx, input logic [31:0] base, input int pad_from);
        if (mon_q.size() >= start + 32) begin
            for (int k = 0; k < 32; k++) begin
                check($sformatf("addr[%0d]", start + k), 64'(mon_q[start+k].addr), 64'(k));
                check($sformatf("data[%0d]", start + k), mon_q[start+k].data,
                      (k < pad_from) ? 64'(base + k) : 64'd0);
                check($sformatf("index[%0d]", start + k), 64'(mon_q[start+k].idx), 64'(idx));
            end
        end
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_out_index", 64'(out_index), 64'd0);
        check("rst_out_data", out_data[63:0], 64'd0);
        check("rst_inflight", 64'(inflight), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("s_ready_first_cycle", 64'(s_ready), 64'd0);
        @(negedge clk);
        check("s_ready_rise", 64'(s_ready), 64'd1);

        // Single job, full rate
        send_job(32'h1234, 32'd0, 31);
        wait_beats("job1_beats", 32, 200);
        check_job(0, 32'h1234, 32'd0, 32);
        if (mon_q.size() >= 32 && in_cyc_q.size() >= 1) begin
            check("latency", 64'(mon_q[0].cyc - in_cyc_q[0]), 64'd1);
            check("throughput", 64'(mon_q[31].cyc - mon_q[0].cyc), 64'd31);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("job1_inflight", 64'(inflight), 64'd1);
        pulse_done();
        @(negedge clk);
        check("job1_retired", 64'(inflight), 64'd0);

        // Backpressure 1-0-0-1
        mon_q.delete();
        saw_block = 1'b0;
        fork
            send_job(32'h55, 32'd100, 31);
            begin
                for (int i = 0; mon_q.size() < 32 && i < 600; i++) begin
                    @(posedge clk); #1;
                    down_ready = bp_pat[i % 4];
                end
                down_ready = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        check("bp_count", 64'(mon_q.size()), 64'd32);
        check_job(0, 32'h55, 32'd100, 32);
        check("bp_s_ready_drop", 64'(saw_block), 64'd1);
        pulse_done();

        // Credit limit and init gap
        mon_q.delete();
        fork
            for (int j = 0; j < 17; j++) send_job(32'h100 + j, 32'(j * 32), 31);
            begin
                for (int c = 0; count31() < 16 && c < 3000; c++) @(posedge clk);
            end
        join
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("credit_held_count31", 64'(count31()), 64'd16);
        check("credit_beats", 64'(mon_q.size()), 64'd543);
        check("credit_inflight_peak", 64'(inflight), 64'd16);
        check("credit_gated_valid", 64'(out_valid), 64'd0);
        check("credit_gated_addr", 64'(out_addr), 64'd31);
        prev_c = -1;
        foreach (mon_q[i]) begin
            if (mon_q[i].addr == 5'd31) begin
                if (prev_c >= 0) check("init_gap", 64'(mon_q[i].cyc - prev_c), 64'd40);
                prev_c = mon_q[i].cyc;
            end
        end
        @(posedge clk); #1;
        done = 1'b1;
        @(negedge clk);
        check("done_lag_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_release_valid", 64'(out_valid), 64'd1);
        check("done_release_inflight", 64'(inflight), 64'd15);
        @(posedge clk); #1;
        done = 1'b0;
        @(negedge clk);
        check("inflight_simul", 64'(inflight), 64'd15);
        check("job17_addr", 64'(mon_q[mon_q.size()-1].addr), 64'd31);
        check("job17_index", 64'(mon_q[mon_q.size()-1].idx), 64'h110);
        for (int i = 0; i < 15; i++) pulse_done();
        @(negedge clk);
        check("drain_inflight", 64'(inflight), 64'd0);
        check("no_err_yet", 64'(err), 64'd0);

        // Framing: s_last at beat 9
        mon_q.delete();
        send_job(32'hAA, 32'd0, 9);
        send_job(32'hBB, 32'd500, 31);
        wait_beats("frame_beats", 64, 2000);
        check_job(0, 32'hAA, 32'd0, 10);
        check_job(32, 32'hBB, 32'd500, 32);
        @(negedge clk);
        check("frame_err", 64'(err), 64'd1);

        // Reset mid-job
        mon_q.delete();
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) send_beat(32'(k), (k == 0) ? 32'hCC : 32'h0, 1'b0);
        wait_beats("partial_beats", 16, 200);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_s_ready", 64'(s_ready), 64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_addr", 64'(out_addr), 64'd0);
        check("mid_rst_out_index", 64'(out_index), 64'd0);
        check("mid_rst_out_data", out_data[63:0], 64'd0);
        check("mid_rst_inflight", 64'(inflight), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        @(negedge clk);
        check("mid_rst_s_ready_rise", 64'(s_ready), 64'd1);
        pulse_done();
        @(negedge clk);
        check("credit_err", 64'(err), 64'd1);
        check("credit_no_underflow", 64'(inflight), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mon_q.delete();
        send_job(32'hDD, 32'h700, 31);
        wait_beats("post_rst_beats", 32, 200);
        check_job(0, 32'hDD, 32'h700, 32);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("post_rst_inflight", 64'(inflight), 64'd1);
        check("post_rst_err", 64'(err), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
